// File: rtl/imem_pkg.sv
// Shared types and default widths for the instruction memory bank.
package imem_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int INSTR_W_DEF = 19;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-port-write, synchronous-read RAM; read returns same-cycle write data (write-first).
// Read data registers only on re and holds otherwise.
module imem_ram
  import imem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 4096
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_rdata <= (we && (waddr == raddr)) ? wdata : r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/imem_bank.sv
// Instruction memory bank: zero-fill sweep after reset (busy), then 1-cycle fetch and load port.
// Out-of-range fetches answer with zero + rd_err; dropped writes pulse wr_err.
module imem_bank
  import imem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               busy,
  output logic               rd_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic               rd_err,
  output logic               wr_err
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(DEPTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W:0]    r_clr_cnt;
  logic [ADDR_W:0]    w_clr_cnt_nxt;
  logic               r_rd_valid;
  logic               r_rd_err;
  logic               r_wr_err;
  logic               r_zero;

  logic               w_busy;
  logic               w_wr_in;
  logic               w_rd_in;
  logic               w_rd_acc;
  logic               w_ram_we;
  logic               w_ram_re;
  logic [ADDR_W-1:0]  w_ram_waddr;
  logic [INSTR_W-1:0] w_ram_wdata;
  logic [INSTR_W-1:0] w_ram_rdata;

  assign w_wr_in = ({1'b0, wr_addr} < DEPTH_X);
  assign w_rd_in = ({1'b0, rd_addr} < DEPTH_X);

  // The sweep borrows the only RAM write port; the load port is muxed out while busy.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_busy        = 1'b0;
    w_ram_we      = 1'b0;
    w_ram_waddr   = wr_addr;
    w_ram_wdata   = wr_data;
    case (r_state)
      ST_CLEAR: begin
        w_busy        = 1'b1;
        w_ram_we      = 1'b1;
        w_ram_waddr   = r_clr_cnt[ADDR_W-1:0];
        w_ram_wdata   = '0;
        w_clr_cnt_nxt = r_clr_cnt + (ADDR_W+1)'(1);
        if (r_clr_cnt == LAST_X) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_ram_we = wr_en & w_wr_in;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  assign w_rd_acc = rd_req & ~w_busy;
  assign w_ram_re = w_rd_acc & w_rd_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_clr_cnt  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_wr_err   <= 1'b0;
      r_zero     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_cnt  <= w_clr_cnt_nxt;
      r_rd_valid <= w_rd_acc;
      r_rd_err   <= w_rd_acc & ~w_rd_in;
      r_wr_err   <= wr_en & (w_busy | ~w_wr_in);
      // r_zero masks the RAM output after reset and for error responses; RAM data holds otherwise.
      if (w_rd_acc) begin
        r_zero <= ~w_rd_in;
      end
    end
  end

  imem_ram #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (w_ram_waddr),
    .wdata (w_ram_wdata),
    .re    (w_ram_re),
    .raddr (rd_addr),
    .rdata (w_ram_rdata)
  );

  assign busy        = w_busy;
  assign rd_valid    = r_rd_valid;
  assign rd_err      = r_rd_err;
  assign wr_err      = r_wr_err;
  assign instruction = r_zero ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_imem_bank.sv
// Directed bench for imem_bank (ADDR_W=4, DEPTH=12) with a cycle model and literal spot checks.
module tb_imem_bank;

  localparam int AW    = 4;
  localparam int IW    = 19;
  localparam int DEPTH = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic          rd_valid;
  logic [IW-1:0] instruction;
  logic          rd_err;
  logic          wr_err;

  int checks   = 0;
  int failures = 0;

  imem_bank #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .busy        (busy),
    .rd_valid    (rd_valid),
    .instruction (instruction),
    .rd_err      (rd_err),
    .wr_err      (wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Behavioural model: countdown of remaining busy cycles plus a word array.
  logic [IW-1:0] m_mem [16];
  int            m_left = 0;
  bit            m_ok   = 1'b0;
  bit            m_b;
  logic          e_busy, e_valid, e_err, e_werr;
  logic [IW-1:0] e_instr;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_ok    = 1'b1;
      m_left  = DEPTH;
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      e_valid = 1'b0;
      e_err   = 1'b0;
      e_werr  = 1'b0;
      e_instr = '0;
    end else if (m_ok) begin
      m_b     = (m_left > 0);
      e_werr  = wr_en && (m_b || (int'(wr_addr) >= DEPTH));
      e_valid = !m_b && rd_req;
      e_err   = e_valid && (int'(rd_addr) >= DEPTH);
      if (e_valid) begin
        if (e_err) e_instr = '0;
        else if (wr_en && wr_addr == rd_addr) e_instr = wr_data;
        else e_instr = m_mem[rd_addr];
      end
      if (!m_b && wr_en && int'(wr_addr) < DEPTH) m_mem[wr_addr] = wr_data;
      if (m_left > 0) m_left--;
    end
    e_busy = (m_left > 0);
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cmp_busy",  32'(busy),        32'(e_busy));
      chk("cmp_valid", 32'(rd_valid),    32'(e_valid));
      chk("cmp_rderr", 32'(rd_err),      32'(e_err));
      chk("cmp_wrerr", 32'(wr_err),      32'(e_werr));
      chk("cmp_instr", 32'(instruction), 32'(e_instr));
    end
  end

  task automatic wait_sweep(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  task automatic read_all(input bit pat);
    logic [31:0] exp;
    exp = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_req  = 1'b1;
      rd_addr = AW'(a);
      tick();
      exp = pat ? (32'h10000 | 32'(a)) : 32'h0;
      chk("rd_vld", 32'(rd_valid), 32'd1);
      chk("rd_err", 32'(rd_err), 32'd0);
      chk("rd_dat", 32'(instruction), exp);
    end
    rd_req = 1'b0;
    tick();
    chk("idle_vld", 32'(rd_valid), 32'd0);
    chk("hold_dat", 32'(instruction), exp);
  endtask

  initial begin
    int n;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
    tick();
    tick();
    chk("rst_busy",  32'(busy), 32'd1);
    chk("rst_vld",   32'(rd_valid), 32'd0);
    chk("rst_rderr", 32'(rd_err), 32'd0);
    chk("rst_wrerr", 32'(wr_err), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);

    rst = 1'b0;
    wait_sweep(n);
    chk("busy_len", 32'(n), 32'd12);
    read_all(1'b0);

    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = IW'(32'h10000 | 32'(i));
      tick();
    end
    wr_en = 1'b0;
    read_all(1'b1);

    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 19'h5A5A5;
    tick();
    wr_en = 1'b0; rd_req = 1'b1; rd_addr = 4'd3;
    tick();
    chk("wr3_vld", 32'(rd_valid), 32'd1);
    chk("wr3_dat", 32'(instruction), 32'h5A5A5);

    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 19'h00123; rd_req = 1'b1; rd_addr = 4'd7;
    tick();
    chk("wfirst_dat", 32'(instruction), 32'h00123);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 19'h7FFFF; rd_req = 1'b1; rd_addr = 4'd8;
    tick();
    chk("diff_old8", 32'(instruction), 32'h10008);
    wr_en = 1'b0; rd_req = 1'b1; rd_addr = 4'd7;
    tick();
    chk("rd7_new", 32'(instruction), 32'h7FFFF);

    rd_req = 1'b1; rd_addr = 4'd13;
    tick();
    chk("oor_vld", 32'(rd_valid), 32'd1);
    chk("oor_err", 32'(rd_err), 32'd1);
    chk("oor_dat", 32'(instruction), 32'd0);
    rd_req = 1'b0;
    tick();
    chk("after_vld", 32'(rd_valid), 32'd0);
    chk("after_err", 32'(rd_err), 32'd0);
    chk("after_dat", 32'(instruction), 32'd0);

    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 19'h7FFFF;
    tick();
    chk("wr15_err", 32'(wr_err), 32'd1);
    wr_en = 1'b0; rd_req = 1'b1; rd_addr = 4'd3;
    tick();
    chk("wr15_pulse", 32'(wr_err), 32'd0);
    chk("rd3_keep", 32'(instruction), 32'h5A5A5);
    rd_req = 1'b0;
    tick();

    rst = 1'b1; rd_req = 1'b1; rd_addr = 4'd3;
    tick();
    rst = 1'b0; rd_req = 1'b0;
    chk("rstfetch_vld", 32'(rd_valid), 32'd0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("rst2_busy", 32'(busy), 32'd1);
    chk("rst2_vld",  32'(rd_valid), 32'd0);
    rst = 1'b0; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 19'h12345; rd_req = 1'b1; rd_addr = 4'd2;
    tick();
    chk("busy_wrerr", 32'(wr_err), 32'd1);
    chk("busy_novld", 32'(rd_valid), 32'd0);
    wr_en = 1'b0; rd_req = 1'b0;
    wait_sweep(n);
    chk("busy_len2", 32'(n + 1), 32'd12);
    read_all(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
